// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vend_pkg
// Description : Shared types and coin constants for the soda vending
//               transaction sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package vend_pkg;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_e;

  // Coin presented to the change hopper
  typedef enum logic [1:0] {
    NONE   = 2'b00,
    NICKEL = 2'b01,
    DIME   = 2'b10
  } coin_e;

  // Coin values in nickel units
  localparam int unsigned NICKEL_V  = 1;
  localparam int unsigned DIME_V    = 2;
  localparam int unsigned QUARTER_V = 5;

endpackage
`default_nettype wire

// File: rtl/vend_txn_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : vend_txn_controller_if
// Description : Coin acceptor / cancel inputs and dispense / hopper outputs
//               of the vending transaction sequencer. The slave modport is
//               the sequencer side, master is the side driving the coins.
// Revision    : 1.0 - initial release
// ============================================================================
interface vend_txn_controller_if #(
  parameter int unsigned CREDIT_W = 4
);
  import vend_pkg::*;

  logic                nickle_i;
  logic                dime_i;
  logic                quarter_i;
  logic                cancel_i;
  logic                change_ready_i;
  logic                soda_o;
  logic                change_valid_o;
  coin_e               change_coin_o;
  logic                coin_reject_o;
  logic [CREDIT_W-1:0] credit_o;
  logic                busy_o;

  modport slave (
    input  nickle_i, dime_i, quarter_i, cancel_i, change_ready_i,
    output soda_o, change_valid_o, change_coin_o, coin_reject_o, credit_o, busy_o
  );

  modport master (
    output nickle_i, dime_i, quarter_i, cancel_i, change_ready_i,
    input  soda_o, change_valid_o, change_coin_o, coin_reject_o, credit_o, busy_o
  );

endinterface
`default_nettype wire

// File: rtl/vend_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : vend_change_dispenser
// Description : Pays out a loaded amount one coin at a time over a
//               valid/ready handshake. Greedy selection (dime while at least
//               two nickels remain, else nickel); coin and valid are held
//               until accepted and the next coin follows without a bubble.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                i_load,
  input  logic [CREDIT_W-1:0] i_amount,
  input  logic                i_ready,
  output logic                o_valid,
  output coin_e               o_coin,
  output logic                o_fire,
  output logic [CREDIT_W-1:0] o_fire_value,
  output logic                o_done
);

  localparam logic [CREDIT_W-1:0] c_nickel_v = CREDIT_W'(NICKEL_V);
  localparam logic [CREDIT_W-1:0] c_dime_v   = CREDIT_W'(DIME_V);

  logic [CREDIT_W-1:0] r_remaining;
  logic                r_valid;
  coin_e               r_coin;

  logic                w_fire;
  logic [CREDIT_W-1:0] w_fire_value;
  logic [CREDIT_W-1:0] w_rem_next;
  logic [CREDIT_W-1:0] w_src;

  function automatic coin_e greedy_coin(input logic [CREDIT_W-1:0] amt);
    if (amt >= c_dime_v) begin
      return DIME;
    end else if (amt != '0) begin
      return NICKEL;
    end else begin
      return NONE;
    end
  endfunction

  assign w_fire       = r_valid && i_ready;
  assign w_fire_value = (r_coin == DIME) ? c_dime_v : c_nickel_v;
  assign w_rem_next   = r_remaining - w_fire_value;
  assign w_src        = i_load ? i_amount : w_rem_next;

  // Load a new payout or advance to the next coin after each accepted one
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_remaining <= '0;
      r_valid     <= 1'b0;
      r_coin      <= NONE;
    end else if (i_load || w_fire) begin
      r_remaining <= w_src;
      r_valid     <= (w_src != '0);
      r_coin      <= greedy_coin(w_src);
    end
  end

  assign o_valid      = r_valid;
  assign o_coin       = r_coin;
  assign o_fire       = w_fire;
  assign o_fire_value = w_fire_value;
  assign o_done       = w_fire && (w_rem_next == '0);

endmodule
`default_nettype wire

// File: rtl/vend_txn_controller.sv
`default_nettype none
// ============================================================================
// Module      : vend_txn_controller
// Description : Soda vending transaction sequencer. Accumulates coin credit
//               in nickel units, issues a one-cycle vend once the price is
//               reached, then pays out change or a cancel refund through the
//               change dispenser. All outputs are registered.
//               Optional macro VEND_TIMEOUT_EN: auto-refund after
//               TIMEOUT_CYCLES cycles in COLLECT without an accepted coin.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_txn_controller
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W       = 4,
  parameter int unsigned PRICE          = 4,
  parameter int unsigned MAX_CREDIT     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  vend_txn_controller_if.slave  bus
);

  localparam logic [CREDIT_W-1:0] c_price     = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   c_max_sum   = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] c_nickel_v  = CREDIT_W'(NICKEL_V);
  localparam logic [CREDIT_W-1:0] c_dime_v    = CREDIT_W'(DIME_V);
  localparam logic [CREDIT_W-1:0] c_quarter_v = CREDIT_W'(QUARTER_V);

  // Elaboration guard on the parameter set
  if (PRICE < 1 || PRICE > MAX_CREDIT || MAX_CREDIT >= (1 << CREDIT_W) ||
      TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("vend_txn_controller: inconsistent PRICE/MAX_CREDIT/CREDIT_W/TIMEOUT_CYCLES");
  end

  state_e              r_state;
  state_e              w_next_state;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_soda;
  logic                r_reject;
  logic                r_busy;

  logic                w_any_coin;
  logic                w_multi_coin;
  logic [CREDIT_W-1:0] w_coin_value;
  logic [CREDIT_W:0]   w_sum;
  logic                w_coin_fits;
  logic [CREDIT_W-1:0] w_vend_rem;
  logic                w_accept;
  logic                w_reject;
  logic                w_load;
  logic [CREDIT_W-1:0] w_load_amount;
  logic                w_timeout;

  logic                w_disp_valid;
  coin_e               w_disp_coin;
  logic                w_disp_fire;
  logic [CREDIT_W-1:0] w_disp_fire_value;
  logic                w_disp_done;

  assign w_any_coin   = bus.nickle_i | bus.dime_i | bus.quarter_i;
  assign w_multi_coin = (bus.nickle_i & bus.dime_i) | (bus.nickle_i & bus.quarter_i) |
                        (bus.dime_i & bus.quarter_i);
  assign w_coin_value = bus.nickle_i ? c_nickel_v : (bus.dime_i ? c_dime_v : c_quarter_v);
  // One extra bit so the ceiling comparison never sees a wrapped sum
  assign w_sum        = {1'b0, r_credit} + {1'b0, w_coin_value};
  assign w_coin_fits  = !w_multi_coin && (w_sum <= c_max_sum);
  assign w_vend_rem   = r_credit - c_price;

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned c_tmo_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);

  logic [c_tmo_w-1:0] r_tmo_cnt;

  // Count cycles spent in COLLECT since the last accepted coin
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tmo_cnt <= '0;
    end else if (r_state != COLLECT || w_accept) begin
      r_tmo_cnt <= '0;
    end else if (!w_timeout) begin
      r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
    end
  end

  assign w_timeout = (r_state == COLLECT) && (r_tmo_cnt == c_tmo_last);
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state, coin accept/reject and dispenser load decisions
  always_comb begin
    w_next_state  = r_state;
    w_accept      = 1'b0;
    w_reject      = 1'b0;
    w_load        = 1'b0;
    w_load_amount = r_credit;
    case (r_state)
      IDLE: begin
        if (w_any_coin) begin
          if (w_coin_fits) begin
            w_accept     = 1'b1;
            w_next_state = COLLECT;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (r_credit >= c_price) begin
          w_next_state = VEND;
          w_reject     = w_any_coin;
        end else if (bus.cancel_i || w_timeout) begin
          // Refund the full credit; a coin arriving alongside is returned
          w_next_state = CHANGE;
          w_load       = 1'b1;
          w_reject     = w_any_coin;
        end else if (w_any_coin) begin
          w_accept = w_coin_fits;
          w_reject = !w_coin_fits;
        end
      end
      VEND: begin
        w_reject = w_any_coin;
        if (w_vend_rem != '0) begin
          w_next_state  = CHANGE;
          w_load        = 1'b1;
          w_load_amount = w_vend_rem;
        end else begin
          w_next_state = IDLE;
        end
      end
      CHANGE: begin
        w_reject = w_any_coin;
        if (w_disp_done) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State register and registered status outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_soda   <= 1'b0;
      r_reject <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_soda   <= (w_next_state == VEND);
      r_reject <= w_reject;
      r_busy   <= (w_next_state == VEND) || (w_next_state == CHANGE);
    end
  end

  // Credit: add accepted coins, take the price on leaving VEND, pay out change
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_credit <= '0;
    end else if (w_accept) begin
      r_credit <= w_sum[CREDIT_W-1:0];
    end else if (r_state == VEND) begin
      r_credit <= w_vend_rem;
    end else if (w_disp_fire) begin
      r_credit <= r_credit - w_disp_fire_value;
    end
  end

  vend_change_dispenser #(
    .CREDIT_W (CREDIT_W)
  ) u_dispenser (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .i_load       (w_load),
    .i_amount     (w_load_amount),
    .i_ready      (bus.change_ready_i),
    .o_valid      (w_disp_valid),
    .o_coin       (w_disp_coin),
    .o_fire       (w_disp_fire),
    .o_fire_value (w_disp_fire_value),
    .o_done       (w_disp_done)
  );

  assign bus.soda_o         = r_soda;
  assign bus.change_valid_o = w_disp_valid;
  assign bus.change_coin_o  = w_disp_coin;
  assign bus.coin_reject_o  = r_reject;
  assign bus.credit_o       = r_credit;
  assign bus.busy_o         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_vend_txn_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_vend_txn_controller
// Description : Self-checking bench for vend_txn_controller (PRICE=4,
//               MAX_CREDIT=10) plus a PRICE=10 instance for the credit
//               ceiling. Cycle vectors are checked against a table; change
//               coins are checked against a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_txn_controller;
  import vend_pkg::*;

  localparam int unsigned CREDIT_W = 4;

  logic clk_i_tb = 1'b0;
  logic rst_ni_tb;

  vend_txn_controller_if #(.CREDIT_W(CREDIT_W)) bus ();
  vend_txn_controller_if #(.CREDIT_W(CREDIT_W)) bus_hi ();

  vend_txn_controller #(
    .CREDIT_W(CREDIT_W), .PRICE(4), .MAX_CREDIT(10), .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk_i (clk_i_tb),
    .rst_ni(rst_ni_tb),
    .bus   (bus)
  );

  vend_txn_controller #(
    .CREDIT_W(CREDIT_W), .PRICE(10), .MAX_CREDIT(10), .TIMEOUT_CYCLES(1000)
  ) dut_hi (
    .clk_i (clk_i_tb),
    .rst_ni(rst_ni_tb),
    .bus   (bus_hi)
  );

  always #5 clk_i_tb = ~clk_i_tb;

  // ins = {nickel, dime, quarter, cancel, ready}; flags = {soda, valid, reject, busy}
  typedef struct {
    logic [4:0] ins;
    int         credit;
    logic [3:0] flags;
    coin_e      coin;
    coin_e      push0;
    coin_e      push1;
  } vec_t;

  vec_t  vecs[$];
  coin_e exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  function automatic vec_t mk(input logic [4:0] ins, input int credit, input logic [3:0] flags,
                              input coin_e coin, input coin_e p0, input coin_e p1);
    vec_t v;
    v.ins = ins; v.credit = credit; v.flags = flags; v.coin = coin; v.push0 = p0; v.push1 = p1;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s idx=%0d actual=%0d required=%0d", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i_tb);
    #1;
  endtask

  task automatic drive(input logic [4:0] ins);
    {bus.nickle_i, bus.dime_i, bus.quarter_i, bus.cancel_i, bus.change_ready_i} = ins;
  endtask

  task automatic drive_hi(input logic [4:0] ins);
    {bus_hi.nickle_i, bus_hi.dime_i, bus_hi.quarter_i, bus_hi.cancel_i, bus_hi.change_ready_i} = ins;
  endtask

  task automatic chk_outs(input string tag, input int idx, input int credit, input logic [3:0] flags,
                          input coin_e coin);
    chk({tag, "_credit"}, idx, int'(bus.credit_o), credit);
    chk({tag, "_soda"},   idx, int'(bus.soda_o), int'(flags[3]));
    chk({tag, "_valid"},  idx, int'(bus.change_valid_o), int'(flags[2]));
    chk({tag, "_reject"}, idx, int'(bus.coin_reject_o), int'(flags[1]));
    chk({tag, "_busy"},   idx, int'(bus.busy_o), int'(flags[0]));
    chk({tag, "_coin"},   idx, int'(bus.change_coin_o), int'(coin));
  endtask

  // Scoreboard: every accepted change coin must match the next expected one
  always @(negedge clk_i_tb) begin
    if (rst_ni_tb && bus.change_valid_o && bus.change_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected coin actual=%0d required=none", int'(bus.change_coin_o));
      end else begin
        coin_e c;
        c = exp_q.pop_front();
        chk("sb_coin", -1, int'(bus.change_coin_o), int'(c));
      end
    end
  end

  initial begin
    rst_ni_tb = 1'b0;
    drive(5'b00000);
    drive_hi(5'b00000);

    // Quarter: vend, one nickel change
    vecs.push_back(mk(5'b00101, 5, 4'b0000, NONE,   NICKEL, NONE));
    vecs.push_back(mk(5'b00001, 5, 4'b1001, NONE,   NONE,   NONE));
    vecs.push_back(mk(5'b00001, 1, 4'b0101, NICKEL, NONE,   NONE));
    vecs.push_back(mk(5'b00001, 0, 4'b0000, NONE,   NONE,   NONE));
    // Dime, dime: exact price, no change
    vecs.push_back(mk(5'b01001, 2, 4'b0000, NONE,   NONE,   NONE));
    vecs.push_back(mk(5'b01001, 4, 4'b0000, NONE,   NONE,   NONE));
    vecs.push_back(mk(5'b00001, 4, 4'b1001, NONE,   NONE,   NONE));
    vecs.push_back(mk(5'b00001, 0, 4'b0000, NONE,   NONE,   NONE));
    // Nickel, dime, cancel: refund dime then nickel
    vecs.push_back(mk(5'b10001, 1, 4'b0000, NONE,   NONE,   NONE));
    vecs.push_back(mk(5'b01001, 3, 4'b0000, NONE,   NONE,   NONE));
    vecs.push_back(mk(5'b00011, 3, 4'b0101, DIME,   DIME,   NICKEL));
    vecs.push_back(mk(5'b00001, 1, 4'b0101, NICKEL, NONE,   NONE));
    vecs.push_back(mk(5'b00001, 0, 4'b0000, NONE,   NONE,   NONE));
    // Two coins at once rejected; cancel in IDLE ignored
    vecs.push_back(mk(5'b11001, 0, 4'b0010, NONE,   NONE,   NONE));
    vecs.push_back(mk(5'b00011, 0, 4'b0000, NONE,   NONE,   NONE));
    // Coin at price-reached cycle and during VEND rejected
    vecs.push_back(mk(5'b01000, 2, 4'b0000, NONE,   NONE,   NONE));
    vecs.push_back(mk(5'b01000, 4, 4'b0000, NONE,   NONE,   NONE));
    vecs.push_back(mk(5'b01000, 4, 4'b1011, NONE,   NONE,   NONE));
    vecs.push_back(mk(5'b10000, 0, 4'b0010, NONE,   NONE,   NONE));
    vecs.push_back(mk(5'b00000, 0, 4'b0000, NONE,   NONE,   NONE));
    // Cancel wins over a simultaneous dime
    vecs.push_back(mk(5'b10001, 1, 4'b0000, NONE,   NONE,   NONE));
    vecs.push_back(mk(5'b01011, 1, 4'b0111, NICKEL, NICKEL, NONE));
    vecs.push_back(mk(5'b00001, 0, 4'b0000, NONE,   NONE,   NONE));
    // Hopper stalls five cycles; coin during CHANGE rejected
    vecs.push_back(mk(5'b00100, 5, 4'b0000, NONE,   NICKEL, NONE));
    vecs.push_back(mk(5'b00000, 5, 4'b1001, NONE,   NONE,   NONE));
    vecs.push_back(mk(5'b00000, 1, 4'b0101, NICKEL, NONE,   NONE));
    vecs.push_back(mk(5'b00000, 1, 4'b0101, NICKEL, NONE,   NONE));
    vecs.push_back(mk(5'b10000, 1, 4'b0111, NICKEL, NONE,   NONE));
    vecs.push_back(mk(5'b00000, 1, 4'b0101, NICKEL, NONE,   NONE));
    vecs.push_back(mk(5'b00000, 1, 4'b0101, NICKEL, NONE,   NONE));
    vecs.push_back(mk(5'b00000, 1, 4'b0101, NICKEL, NONE,   NONE));
    vecs.push_back(mk(5'b00001, 0, 4'b0000, NONE,   NONE,   NONE));
    // Nickel, dime, quarter = 8: vend then two dimes back
    vecs.push_back(mk(5'b10001, 1, 4'b0000, NONE,   NONE,   NONE));
    vecs.push_back(mk(5'b01001, 3, 4'b0000, NONE,   NONE,   NONE));
    vecs.push_back(mk(5'b00101, 8, 4'b0000, NONE,   DIME,   DIME));
    vecs.push_back(mk(5'b00001, 8, 4'b1001, NONE,   NONE,   NONE));
    vecs.push_back(mk(5'b00001, 4, 4'b0101, DIME,   NONE,   NONE));
    vecs.push_back(mk(5'b00001, 2, 4'b0101, DIME,   NONE,   NONE));
    vecs.push_back(mk(5'b00001, 0, 4'b0000, NONE,   NONE,   NONE));

    // Reset state
    repeat (3) @(posedge clk_i_tb);
    #1;
    chk_outs("reset", -1, 0, 4'b0000, NONE);
    rst_ni_tb = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ins);
      if (vecs[i].push0 != NONE) exp_q.push_back(vecs[i].push0);
      if (vecs[i].push1 != NONE) exp_q.push_back(vecs[i].push1);
      step();
      chk_outs("vec", i, vecs[i].credit, vecs[i].flags, vecs[i].coin);
    end
    drive(5'b00000);
    step();

    // Credit ceiling on the PRICE=10 instance
    drive_hi(5'b10001); step();
    chk("hi_credit1", 0, int'(bus_hi.credit_o), 1);
    drive_hi(5'b00101); step();
    chk("hi_credit6", 1, int'(bus_hi.credit_o), 6);
    drive_hi(5'b00101); step();
    chk("hi_ceiling_reject", 2, int'(bus_hi.coin_reject_o), 1);
    chk("hi_ceiling_credit", 2, int'(bus_hi.credit_o), 6);
    drive_hi(5'b01001); step();
    chk("hi_credit8", 3, int'(bus_hi.credit_o), 8);
    drive_hi(5'b01001); step();
    chk("hi_at_max_reject", 4, int'(bus_hi.coin_reject_o), 0);
    chk("hi_at_max_credit", 4, int'(bus_hi.credit_o), 10);
    drive_hi(5'b00001); step();
    chk("hi_soda", 5, int'(bus_hi.soda_o), 1);
    step();
    chk("hi_done_credit", 6, int'(bus_hi.credit_o), 0);
    chk("hi_done_valid", 6, int'(bus_hi.change_valid_o), 0);
    chk("hi_done_busy", 6, int'(bus_hi.busy_o), 0);
    drive_hi(5'b00000);

    // Asynchronous reset while a refund is stalled in CHANGE
    drive(5'b10000); step();
    drive(5'b01000); step();
    drive(5'b00010); step();
    chk("prerst_valid", -1, int'(bus.change_valid_o), 1);
    drive(5'b00000);
    #2 rst_ni_tb = 1'b0;
    #1;
    chk_outs("async_rst", -1, 0, 4'b0000, NONE);
    exp_q.delete();
    step();
    rst_ni_tb = 1'b1;
    step();
    chk_outs("post_rst", -1, 0, 4'b0000, NONE);

`ifdef VEND_TIMEOUT_EN
    // Nickel then idle: auto-refund after the timeout
    drive(5'b10001); step();
    chk("tmo_credit", -1, int'(bus.credit_o), 1);
    drive(5'b00001);
    repeat (999) step();
    chk("tmo_before_valid", -1, int'(bus.change_valid_o), 0);
    exp_q.push_back(NICKEL);
    step();
    chk("tmo_valid", -1, int'(bus.change_valid_o), 1);
    chk("tmo_coin", -1, int'(bus.change_coin_o), int'(NICKEL));
    step();
    chk_outs("tmo_done", -1, 0, 4'b0000, NONE);
`else
    // Without the timeout COLLECT waits, then cancel refunds
    drive(5'b10001); step();
    drive(5'b00001);
    repeat (1000) step();
    chk_outs("wait", -1, 1, 4'b0000, NONE);
    drive(5'b00011);
    exp_q.push_back(NICKEL);
    step();
    chk_outs("wait_refund", -1, 1, 4'b0101, NICKEL);
    drive(5'b00001);
    step();
    chk_outs("wait_done", -1, 0, 4'b0000, NONE);
`endif

    drive(5'b00000);
    step();
    chk("sb_drain", -1, exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
